// File: rtl/pmem_arbiter.sv
// Arbiter sharing one cacheline-adaptor port between icache and dcache line transactions.
// Optional macro ARB_ROUND_ROBIN_EN: simultaneous requests alternate instead of favouring dcache.
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  a_read,
    output logic                  a_write,
    output logic [ADDR_WIDTH-1:0] a_address,
    output logic [LINE_WIDTH-1:0] a_wdata,
    input  logic [LINE_WIDTH-1:0] a_rdata,
    input  logic                  a_resp,
    output logic                  arb_busy,
    output logic                  arb_owner
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  txn_write;
    logic [ADDR_WIDTH-1:0] txn_addr;
    logic [LINE_WIDTH-1:0] txn_wdata;
    logic                  last_owner;
    logic                  i_req;
    logic                  d_req;
    logic                  grant_d;
    logic                  grant_i;
    logic                  serving;

    // Handshake: a requester raises read/write and holds it until its 1-cycle resp pulse;
    // the adaptor side sees read/write held for the whole burst until its own a_resp pulse.
    assign i_req = i_read;
    assign d_req = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    assign grant_d = d_req && (!i_req || !last_owner);
`else
    assign grant_d = d_req;
`endif
    assign grant_i = i_req && !grant_d;

    assign serving = (state == SERVE_I) || (state == SERVE_D);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = SERVE_D;
                end else if (grant_i) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (a_resp) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            txn_write  <= 1'b0;
            txn_addr   <= '0;
            txn_wdata  <= '0;
            last_owner <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_d) begin
                // write wins over read if the dcache ever raises both
                txn_write <= d_write;
                txn_addr  <= d_address;
                txn_wdata <= d_wdata;
            end else if (state == IDLE && grant_i) begin
                txn_write <= 1'b0;
                txn_addr  <= i_address;
            end
            if (serving && a_resp) begin
                last_owner <= (state == SERVE_D);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(d_read && d_write));
        end
    end

    assign a_read    = serving && !txn_write;
    assign a_write   = serving && txn_write;
    assign a_address = txn_addr;
    assign a_wdata   = txn_wdata;

    assign i_resp  = (state == SERVE_I) && a_resp;
    assign d_resp  = (state == SERVE_D) && a_resp;
    assign i_rdata = a_rdata;
    assign d_rdata = a_rdata;

    assign arb_busy  = (state != IDLE);
    // outside a transaction, report whoever was served last
    assign arb_owner = serving ? (state == SERVE_D) : last_owner;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized bench for pmem_arbiter against a transaction-level timing model of the arbiter.
module tb_pmem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_address = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_address = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          a_read;
    logic          a_write;
    logic [AW-1:0] a_address;
    logic [LW-1:0] a_wdata;
    logic [LW-1:0] a_rdata = '0;
    logic          a_resp = 1'b0;
    logic          arb_busy;
    logic          arb_owner;

    pmem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .a_read(a_read), .a_write(a_write), .a_address(a_address), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_resp(a_resp),
        .arb_busy(arb_busy), .arb_owner(arb_owner)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference model: at most one transaction in flight; a new grant is allowed only two
    // cycles after the previous completion; the winner is chosen by the priority rule.
    typedef struct {
        logic          write;
        logic          owner;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } txn_t;

    txn_t exp_q[$];
    int   cyc;
    int   m_done_cyc;
    logic m_last;

    // requester bookkeeping
    logic i_drop;
    int   d_drop_in;

    task automatic model_reset();
        exp_q.delete();
        m_done_cyc = cyc - 10;
        m_last     = 1'b0;
        i_drop     = 1'b0;
        d_drop_in  = 0;
    endtask

    task automatic step();
        txn_t cur;
        txn_t t;
        logic active;
        @(negedge clk);
        if (i_drop) begin
            i_read = 1'b0;
            i_drop = 1'b0;
        end else if (!i_read && $urandom_range(0, 3) == 0) begin
            i_read    = 1'b1;
            i_address = $urandom & 32'hFFFF_FFE0;
        end
        if (d_drop_in > 0) begin
            d_drop_in--;
            if (d_drop_in == 0) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end
        end else if (!d_read && !d_write && $urandom_range(0, 3) == 0) begin
            d_write   = $urandom_range(0, 1);
            d_read    = !d_write;
            d_address = $urandom & 32'hFFFF_FFE0;
            d_wdata   = rand_line();
        end else if ($urandom_range(0, 1) == 0) begin
            d_wdata = rand_line();
        end
        a_rdata = rand_line();
        if (a_read || a_write) a_resp = ($urandom_range(0, 4) == 0);
        else                   a_resp = ($urandom_range(0, 7) == 0);
        #1;

        active = (exp_q.size() != 0);
        if (active) cur = exp_q[0];
        check("a_read",  a_read,  active && !cur.write);
        check("a_write", a_write, active && cur.write);
        check("i_resp",  i_resp,  active && !cur.owner && a_resp);
        check("d_resp",  d_resp,  active && cur.owner && a_resp);
        check("arb_busy", arb_busy, active || (cyc == m_done_cyc + 1));
        check("i_rdata", i_rdata, a_rdata);
        check("d_rdata", d_rdata, a_rdata);
        if (active) begin
            check("a_address", a_address, cur.addr);
            check("arb_owner", arb_owner, cur.owner);
            if (cur.write) check("a_wdata", a_wdata, cur.wdata);
        end

        if (active && a_resp) begin
            void'(exp_q.pop_front());
            m_done_cyc = cyc;
            m_last     = cur.owner;
        end else if (!active && cyc >= m_done_cyc + 2 && (i_read || d_read || d_write)) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (i_read && (d_read || d_write)) t.owner = !m_last;
            else                               t.owner = (d_read || d_write);
`else
            t.owner = (d_read || d_write);
`endif
            t.write = t.owner && d_write;
            t.addr  = t.owner ? d_address : i_address;
            t.wdata = d_wdata;
            exp_q.push_back(t);
        end

        if (i_resp) i_drop = 1'b1;
        if (d_resp) d_drop_in = $urandom_range(1, 2);
        cyc++;
    endtask

    initial begin
        int waited;
        cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_a_read",  a_read,   1'b0);
        check("rst_a_write", a_write,  1'b0);
        check("rst_i_resp",  i_resp,   1'b0);
        check("rst_d_resp",  d_resp,   1'b0);
        check("rst_busy",    arb_busy, 1'b0);
        check("rst_owner",   arb_owner, 1'b0);
        check("rst_a_addr",  a_address, '0);
        check("rst_a_wdata", a_wdata,  '0);
        rst = 1'b0;

        repeat (500) step();

        // reset in the middle of a dcache transaction
        waited = 0;
        while (!(exp_q.size() != 0 && exp_q[0].owner) && waited < 400) begin
            step();
            waited++;
        end
        check("mid_rst_wait", waited < 400, 1'b1);
        repeat (2) begin
            if (exp_q.size() != 0) step();
        end
        @(negedge clk);
        a_resp = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_a_read",  a_read,   1'b0);
        check("mid_rst_a_write", a_write,  1'b0);
        check("mid_rst_d_resp",  d_resp,   1'b0);
        check("mid_rst_busy",    arb_busy, 1'b0);
        a_resp  = 1'b0;
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        cyc++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc++;

        repeat (500) step();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
